sound_i2s_rx: RTL and testbench

// - I2S receiver: deserialises an external I2S stream (SCLK/LRCK/data) into parallel left/right

---
 rtl/sound_i2s_rx.sv | 198 +++++++++++++++++++
 tb/tb_sound_i2s_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCK/DIN in clk_audio and delivers left/right sample pairs.
// Optional macro SOUND_I2S_RX_MONO_EN adds a registered (l+r)/2 output, audio_mono.
module sound_i2s_rx #(
  parameter int CHANNEL_WIDTH = 16,
  parameter int SIGNED_OUTPUT = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_audio,
  input  logic                     reset_n,
  input  logic                     audio_sclk,
  input  logic                     audio_lrck,
  input  logic                     audio_din,
  output logic [CHANNEL_WIDTH-1:0] audio_l,
  output logic [CHANNEL_WIDTH-1:0] audio_r,
  output logic                     sample_valid,
  output logic                     frame_error
`ifdef SOUND_I2S_RX_MONO_EN
  ,
  output logic [CHANNEL_WIDTH-1:0] audio_mono
`endif
);

  localparam int CNT_W = $clog2(CHANNEL_WIDTH + 1);
  localparam int IDX_W = (CHANNEL_WIDTH > 1) ? $clog2(CHANNEL_WIDTH) : 1;
  localparam logic [CNT_W-1:0]         LAST_BIT = CNT_W'(CHANNEL_WIDTH - 1);
  localparam logic [CHANNEL_WIDTH-1:0] MSB_MASK = CHANNEL_WIDTH'(1) << (CHANNEL_WIDTH - 1);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_PAD   = 2'd3;

  function automatic logic [CHANNEL_WIDTH-1:0] f_fmt(input logic [CHANNEL_WIDTH-1:0] w);
    return (SIGNED_OUTPUT != 0) ? w : (w ^ MSB_MASK);
  endfunction

`ifdef SOUND_I2S_RX_MONO_EN
  function automatic logic [CHANNEL_WIDTH-1:0] f_mono(input logic [CHANNEL_WIDTH-1:0] a,
                                                       input logic [CHANNEL_WIDTH-1:0] b);
    logic [CHANNEL_WIDTH:0] s;
    if (SIGNED_OUTPUT != 0) s = {a[CHANNEL_WIDTH-1], a} + {b[CHANNEL_WIDTH-1], b};
    else                    s = {1'b0, a} + {1'b0, b};
    return s[CHANNEL_WIDTH:1];
  endfunction
`endif

  logic [SYNC_STAGES-1:0]   r_sclk_sync;
  logic [SYNC_STAGES-1:0]   r_lrck_sync;
  logic [SYNC_STAGES-1:0]   r_din_sync;
  logic                     r_sclk_prev;
  logic                     r_lrck_prev;
  logic [1:0]               r_state;
  logic                     r_chan;
  logic [CNT_W-1:0]         r_bit_cnt;
  logic [CHANNEL_WIDTH-1:0] r_shift;
  logic [CHANNEL_WIDTH-1:0] r_left_hold;
  logic                     r_left_short;
  logic                     r_have_left;
  logic [CHANNEL_WIDTH-1:0] r_audio_l;
  logic [CHANNEL_WIDTH-1:0] r_audio_r;
  logic                     r_valid;
  logic                     r_ferr;

  logic                     w_sclk;
  logic                     w_lrck;
  logic                     w_din;
  logic                     w_sclk_fall;
  logic                     w_lrck_chg;
  logic [IDX_W-1:0]         w_idx;
  logic [CHANNEL_WIDTH-1:0] w_shift_next;
  logic [CHANNEL_WIDTH-1:0] w_word;
  logic                     w_done;
  logic                     w_short;
  logic                     w_new_slot;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_lrck      = r_lrck_sync[SYNC_STAGES-1];
  assign w_din       = r_din_sync[SYNC_STAGES-1];
  assign w_sclk_fall = r_sclk_prev & ~w_sclk;
  assign w_lrck_chg  = w_lrck ^ r_lrck_prev;
  assign w_idx       = IDX_W'(CHANNEL_WIDTH - 1) - r_bit_cnt[IDX_W-1:0];

  // All three inputs go through equal-depth chains so lrck/din line up with the SCLK edge.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_lrck_sync <= '0;
      r_din_sync  <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], audio_sclk};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], audio_lrck};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], audio_din};
      r_sclk_prev <= w_sclk;
    end
  end

  // Bits are written by position so a word cut short stays left-justified with zero LSBs.
  always_comb begin
    w_shift_next        = r_shift;
    w_shift_next[w_idx] = w_din;
    w_word              = w_shift_next;
    w_done              = 1'b0;
    w_short             = 1'b0;
    w_new_slot          = 1'b0;
    if (w_sclk_fall) begin
      case (r_state)
        S_WAIT:  w_new_slot = r_lrck_prev & ~w_lrck;
        S_DELAY, S_SHIFT: begin
          if (w_lrck_chg) begin
            w_done     = 1'b1;
            w_short    = 1'b1;
            w_word     = r_shift;
            w_new_slot = 1'b1;
          end else if (r_bit_cnt == LAST_BIT) begin
            w_done = 1'b1;
          end
        end
        S_PAD:   w_new_slot = w_lrck_chg;
        default: w_new_slot = 1'b0;
      endcase
    end
  end

  // The fall that reveals an LRCK change is the discarded delay slot of the new word.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_lrck_prev <= 1'b0;
      r_state     <= S_WAIT;
      r_chan      <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
    end else if (w_sclk_fall) begin
      r_lrck_prev <= w_lrck;
      if (w_new_slot) begin
        r_state   <= S_DELAY;
        r_chan    <= w_lrck;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_done) begin
        r_state <= S_PAD;
      end else if (r_state == S_DELAY || r_state == S_SHIFT) begin
        r_state   <= S_SHIFT;
        r_shift   <= w_shift_next;
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // A right word only publishes when a left word has been held since the last commit.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_left_hold  <= '0;
      r_left_short <= 1'b0;
      r_have_left  <= 1'b0;
      r_audio_l    <= '0;
      r_audio_r    <= '0;
      r_valid      <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_done) begin
        if (!r_chan) begin
          r_left_hold  <= w_word;
          r_left_short <= w_short;
          r_have_left  <= 1'b1;
        end else if (r_have_left) begin
          r_audio_l   <= f_fmt(r_left_hold);
          r_audio_r   <= f_fmt(w_word);
          r_valid     <= 1'b1;
          r_ferr      <= r_left_short | w_short;
          r_have_left <= 1'b0;
        end
      end
    end
  end

`ifdef SOUND_I2S_RX_MONO_EN
  logic [CHANNEL_WIDTH-1:0] r_mono;

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_mono <= '0;
    end else if (w_done && r_chan && r_have_left) begin
      r_mono <= f_mono(f_fmt(r_left_hold), f_fmt(w_word));
    end
  end

  assign audio_mono = r_mono;
`endif

  assign audio_l      = r_audio_l;
  assign audio_r      = r_audio_r;
  assign sample_valid = r_valid;
  assign frame_error  = r_ferr;

endmodule

// File: tb/tb_sound_i2s_rx.sv
// Bench for sound_i2s_rx: a signed and an unsigned instance share one I2S stream.
// Define SOUND_I2S_RX_MONO_EN to also check audio_mono.
module tb_sound_i2s_rx;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        fe;
    logic [15:0] mono;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sclk = 1'b0;
  logic lrck = 1'b0;
  logic din = 1'b0;

  logic [15:0] l_s, r_s, l_u, r_u, mono_s, mono_u;
  logic        sv_s, fe_s, sv_u, fe_u;

  int checks = 0;
  int errors = 0;
  int stray = 0;
  int pulses_in_reset = 0;

  ev_t qo_s[$], qe_s[$], qo_u[$], qe_u[$];
  logic [15:0] last_ls = '0, last_rs = '0, last_lu = '0, last_ru = '0;

  // Reference model state: sync status and a held left word.
  bit          m_synced = 0;
  bit          m_prev_right = 0;
  bit          m_have = 0;
  bit          m_lshort = 0;
  logic [15:0] m_hold = '0;

  always #5 clk = ~clk;

  sound_i2s_rx #(.CHANNEL_WIDTH(16), .SIGNED_OUTPUT(1), .SYNC_STAGES(2)) u_dut_s (
    .clk_audio(clk), .reset_n(reset_n), .audio_sclk(sclk), .audio_lrck(lrck),
    .audio_din(din), .audio_l(l_s), .audio_r(r_s), .sample_valid(sv_s), .frame_error(fe_s)
`ifdef SOUND_I2S_RX_MONO_EN
    , .audio_mono(mono_s)
`endif
  );

  sound_i2s_rx #(.CHANNEL_WIDTH(16), .SIGNED_OUTPUT(0), .SYNC_STAGES(3)) u_dut_u (
    .clk_audio(clk), .reset_n(reset_n), .audio_sclk(sclk), .audio_lrck(lrck),
    .audio_din(din), .audio_l(l_u), .audio_r(r_u), .sample_valid(sv_u), .frame_error(fe_u)
`ifdef SOUND_I2S_RX_MONO_EN
    , .audio_mono(mono_u)
`endif
  );

`ifndef SOUND_I2S_RX_MONO_EN
  assign mono_s = '0;
  assign mono_u = '0;
`endif

  always @(negedge clk) begin
    if (!reset_n && (sv_s || sv_u || fe_s || fe_u)) pulses_in_reset++;
    if (fe_s && !sv_s) stray++;
    if (fe_u && !sv_u) stray++;
    if (sv_s) qo_s.push_back('{l: l_s, r: r_s, fe: fe_s, mono: mono_s});
    if (sv_u) qo_u.push_back('{l: l_u, r: r_u, fe: fe_u, mono: mono_u});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f_keep(input logic [15:0] w, input int n);
    logic [31:0] m;
    m = 32'hFFFF << (16 - n);
    return w & m[15:0];
  endfunction

  function automatic logic [15:0] f_mono_ref(input logic [15:0] a, input logic [15:0] b,
                                             input bit sgn);
    int s;
    if (sgn) s = int'($signed(a)) + int'($signed(b));
    else     s = int'(a) + int'(b);
    s = s >>> 1;
    return s[15:0];
  endfunction

  task automatic model_word(input bit chan, input logic [15:0] word, input int nbits);
    logic [15:0] cap, lu, ru;
    bit          sh;
    cap = f_keep(word, nbits);
    sh  = (nbits < 16);
    if (!chan) begin
      m_hold = cap; m_lshort = sh; m_have = 1;
    end else if (m_have) begin
      qe_s.push_back('{l: m_hold, r: cap, fe: m_lshort | sh,
                       mono: f_mono_ref(m_hold, cap, 1'b1)});
      lu = m_hold ^ 16'h8000;
      ru = cap ^ 16'h8000;
      qe_u.push_back('{l: lu, r: ru, fe: m_lshort | sh, mono: f_mono_ref(lu, ru, 1'b0)});
      m_have = 0;
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_prev_right = 0; m_have = 0; m_lshort = 0;
    last_ls = '0; last_rs = '0; last_lu = '0; last_ru = '0;
  endtask

  task automatic drive_bit(input logic l, input logic d);
    sclk = 1'b1; lrck = l; din = d;
    #40;
    sclk = 1'b0;
    #40;
  endtask

  task automatic mid_reset();
    reset_n = 1'b0;
    #100;
    chk("midrst_l_s", 32'(l_s), 32'h0);
    chk("midrst_r_s", 32'(r_s), 32'h0);
    chk("midrst_l_u", 32'(l_u), 32'h0);
    chk("midrst_sv", 32'(sv_s | sv_u), 32'h0);
    reset_n = 1'b1;
    #30;
  endtask

  // One slot: delay bit, nbits data MSB-first, npad random bits; optional reset at bit rst_at.
  task automatic send_slot(input bit chan, input logic [15:0] word, input int nbits,
                           input int npad, input int rst_at);
    logic d;
    bit   hit;
    hit = 0;
    for (int i = 0; i < 1 + nbits + npad; i++) begin
      if (i == rst_at) begin
        mid_reset();
        hit = 1;
      end
      if (i >= 1 && i <= nbits) d = word[16 - i];
      else                      d = 1'($urandom_range(0, 1));
      drive_bit(chan, d);
    end
    if (hit) begin
      model_reset();
      m_prev_right = chan;
    end else begin
      if (!m_synced && !chan && m_prev_right) m_synced = 1;
      if (m_synced) model_word(chan, word, nbits);
      m_prev_right = chan;
    end
  endtask

  task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw);
    send_slot(1'b0, lw, 16, 15, -1);
    send_slot(1'b1, rw, 16, 15, -1);
  endtask

  task automatic cmp_ev(input string tag, input ev_t o, input ev_t e);
    chk({tag, "_l"}, 32'(o.l), 32'(e.l));
    chk({tag, "_r"}, 32'(o.r), 32'(e.r));
    chk({tag, "_fe"}, 32'(o.fe), 32'(e.fe));
`ifdef SOUND_I2S_RX_MONO_EN
    chk({tag, "_mono"}, 32'(o.mono), 32'(e.mono));
`endif
  endtask

  task automatic checkpoint(input string tag);
    ev_t o, e;
    #300;
    chk({tag, "_cnt_s"}, 32'(qo_s.size()), 32'(qe_s.size()));
    chk({tag, "_cnt_u"}, 32'(qo_u.size()), 32'(qe_u.size()));
    while (qe_s.size() > 0 && qo_s.size() > 0) begin
      o = qo_s.pop_front(); e = qe_s.pop_front();
      cmp_ev({tag, "_s"}, o, e);
      last_ls = e.l; last_rs = e.r;
    end
    while (qe_u.size() > 0 && qo_u.size() > 0) begin
      o = qo_u.pop_front(); e = qe_u.pop_front();
      cmp_ev({tag, "_u"}, o, e);
      last_lu = e.l; last_ru = e.r;
    end
    qo_s.delete(); qe_s.delete(); qo_u.delete(); qe_u.delete();
    chk({tag, "_hold_l_s"}, 32'(l_s), 32'(last_ls));
    chk({tag, "_hold_r_s"}, 32'(r_s), 32'(last_rs));
    chk({tag, "_hold_l_u"}, 32'(l_u), 32'(last_lu));
    chk({tag, "_hold_r_u"}, 32'(r_u), 32'(last_ru));
    chk({tag, "_stray_fe"}, 32'(stray), 32'h0);
  endtask

  initial begin
    #2;
    // Active stream while held in reset.
    send_frame(16'h1234, 16'h5678);
    chk("rst_l_s", 32'(l_s), 32'h0);
    chk("rst_r_s", 32'(r_s), 32'h0);
    chk("rst_l_u", 32'(l_u), 32'h0);
    chk("rst_r_u", 32'(r_u), 32'h0);
    chk("rst_pulses", 32'(pulses_in_reset), 32'h0);
    qo_s.delete(); qo_u.delete(); qe_s.delete(); qe_u.delete();

    reset_n = 1'b1;
    model_reset();
    send_frame(16'h8001, 16'h7FFE);
    checkpoint("first_frame");
    send_frame(16'h8001, 16'h7FFE);
    send_frame(16'h8001, 16'h7FFE);
    checkpoint("nominal");

    send_frame(16'h0000, 16'hFFFF);
    checkpoint("unsigned");

    send_frame(16'h7FFF, 16'h0001);
    send_frame(16'h8000, 16'hFFFF);
    checkpoint("mono");

    send_slot(1'b0, 16'h1234, 16, 15, -1);
    send_slot(1'b1, 16'hABCD, 10, 0, -1);
    send_frame(16'h0F0F, 16'hF0F0);
    checkpoint("short");

    send_slot(1'b0, 16'h5555, 16, 15, -1);
    send_slot(1'b1, 16'hAAAA, 16, 15, 5);
    checkpoint("after_midrst");
    send_frame(16'h1357, 16'h2468);
    checkpoint("resync");

    for (int k = 0; k < 6; k++) begin
      send_slot(1'b0, 16'($urandom), 16, $urandom_range(0, 16), -1);
      send_slot(1'b1, 16'($urandom), 16, $urandom_range(0, 16), -1);
    end
    send_frame(16'($urandom), 16'($urandom));
    checkpoint("random");

    chk("final_pulses_in_reset", 32'(pulses_in_reset), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
